// File: rtl/chunk_streamer_if.sv
// chunk_streamer_if -- load / request / chunk-return bundle for chunk_streamer.
// Ports (master = consumer side, slave = chunk_streamer):
//   load_en, load_key[255:0], load_nonce[95:0], load_counter[31:0] : store load
//   chunk_request, request_type[1:0], chunk_index[4:0]             : chunk request
//   chunk_valid, chunk_type[1:0], chunk[31:0], busy, err           : results/status
interface chunk_streamer_if;
    localparam int unsigned KEY_W   = 256;
    localparam int unsigned NONCE_W = 96;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned TYPE_W  = 2;
    localparam int unsigned IDX_W   = 5;

    logic               load_en;
    logic [KEY_W-1:0]   load_key;
    logic [NONCE_W-1:0] load_nonce;
    logic [WORD_W-1:0]  load_counter;
    logic               chunk_request;
    logic [TYPE_W-1:0]  request_type;
    logic [IDX_W-1:0]   chunk_index;
    logic               chunk_valid;
    logic [TYPE_W-1:0]  chunk_type;
    logic [WORD_W-1:0]  chunk;
    logic               busy;
    logic               err;

    modport master (
        output load_en, load_key, load_nonce, load_counter,
        output chunk_request, request_type, chunk_index,
        input  chunk_valid, chunk_type, chunk, busy, err
    );

    modport slave (
        input  load_en, load_key, load_nonce, load_counter,
        input  chunk_request, request_type, chunk_index,
        output chunk_valid, chunk_type, chunk, busy, err
    );
endinterface

// File: rtl/chunk_streamer.sv
// chunk_streamer -- serves 32-bit chunks of a stored key / nonce / counter on request.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : chunk_streamer_if.slave (load, request and chunk-return signals)
// Build option: define CHUNK_STREAMER_AUTOINC_EN to make the stored counter advance
//   by one (wrapping) each time a counter chunk is presented.
// Flow per request: IDLE (sample) -> LOOKUP (select word) -> PRESENT (raise valid)
//   -> HOLDOFF (valid visible, stale request absorbed) -> IDLE.
module chunk_streamer (
    input  logic              clk,
    input  logic              rst,
    chunk_streamer_if.slave   bus
);
    localparam int unsigned KEY_W   = 256;
    localparam int unsigned NONCE_W = 96;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned TYPE_W  = 2;
    localparam int unsigned IDX_W   = 5;

    localparam logic [TYPE_W-1:0] TYPE_KEY   = 2'd0;
    localparam logic [TYPE_W-1:0] TYPE_NONCE = 2'd1;
    localparam logic [TYPE_W-1:0] TYPE_CTR   = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOOKUP  = 2'd1,
        PRESENT = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    state_t state, next_state;

    logic [KEY_W-1:0]   key_store;
    logic [NONCE_W-1:0] nonce_store;
    logic [WORD_W-1:0]  ctr_store;
    logic [TYPE_W-1:0]  req_type;
    logic [IDX_W-1:0]   req_index;

    logic               chunk_valid_q;
    logic               err_q;
    logic               busy_q;
    logic [TYPE_W-1:0]  chunk_type_q;
    logic [WORD_W-1:0]  chunk_q;

    logic               legal;
    logic [WORD_W-1:0]  sel_word;
    logic               store_load;
    logic               latch_req;
    logic               capture;
    logic               valid_d;
    logic               err_d;
    logic               ctr_inc;

    // Legality check and word select for the latched request
    always_comb begin
        legal    = 1'b0;
        sel_word = '0;
        case (req_type)
            TYPE_KEY: begin
                legal    = (req_index < IDX_W'(8));
                sel_word = key_store[{req_index[2:0], 5'd0} +: WORD_W];
            end
            TYPE_NONCE: begin
                legal = (req_index < IDX_W'(3));
                case (req_index[1:0])
                    2'd0:    sel_word = nonce_store[31:0];
                    2'd1:    sel_word = nonce_store[63:32];
                    2'd2:    sel_word = nonce_store[95:64];
                    default: sel_word = '0;
                endcase
            end
            TYPE_CTR: begin
                legal    = (req_index == '0);
                sel_word = ctr_store;
            end
            default: begin
                legal    = 1'b0;
                sel_word = '0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode
    always_comb begin
        next_state = state;
        store_load = 1'b0;
        latch_req  = 1'b0;
        capture    = 1'b0;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        ctr_inc    = 1'b0;
        case (state)
            IDLE: begin
                store_load = bus.load_en;
                if (bus.chunk_request) begin
                    latch_req  = 1'b1;
                    next_state = LOOKUP;
                end
            end
            LOOKUP: begin
                if (legal) begin
                    capture    = 1'b1;
                    next_state = PRESENT;
                end else begin
                    err_d      = 1'b1;
                    next_state = IDLE;
                end
            end
            PRESENT: begin
                valid_d    = 1'b1;
                next_state = HOLDOFF;
`ifdef CHUNK_STREAMER_AUTOINC_EN
                ctr_inc    = (req_type == TYPE_CTR);
`else
                ctr_inc    = 1'b0;
`endif
            end
            HOLDOFF: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Key/nonce/counter stores; a load wins over a counter increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_store   <= '0;
            nonce_store <= '0;
            ctr_store   <= '0;
        end else if (store_load) begin
            key_store   <= bus.load_key;
            nonce_store <= bus.load_nonce;
            ctr_store   <= bus.load_counter;
        end else if (ctr_inc) begin
            ctr_store   <= ctr_store + WORD_W'(1);
        end
    end

    // Request latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_type  <= '0;
            req_index <= '0;
        end else if (latch_req) begin
            req_type  <= bus.request_type;
            req_index <= bus.chunk_index;
        end
    end

    // Registered outputs; chunk/chunk_type hold until the next capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chunk_valid_q <= 1'b0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
            chunk_q       <= '0;
            chunk_type_q  <= '0;
        end else begin
            chunk_valid_q <= valid_d;
            err_q         <= err_d;
            busy_q        <= (next_state != IDLE);
            if (capture) begin
                chunk_q      <= sel_word;
                chunk_type_q <= req_type;
            end
        end
    end

    assign bus.chunk_valid = chunk_valid_q;
    assign bus.err         = err_q;
    assign bus.busy        = busy_q;
    assign bus.chunk       = chunk_q;
    assign bus.chunk_type  = chunk_type_q;

endmodule

// File: tb/tb_chunk_streamer.sv
// tb_chunk_streamer -- self-checking bench for chunk_streamer: table-driven
// requests with a scoreboard of expected chunks/errors, plus hand-written
// streaming, late-load and mid-transfer reset sequences.
module tb_chunk_streamer;
    localparam logic [255:0] K1 = 256'h1F1E1D1C_1B1A1918_17161514_13121110_0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [95:0]  N1 = 96'hCAFEBABE_DEADBEEF_01234567;
    localparam logic [31:0]  C1 = 32'h0000_0010;
    localparam logic [255:0] K2 = 256'hFFEEDDCC_BBAA9988_77665544_33221100_0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    localparam logic [95:0]  N2 = 96'h11112222_33334444_55556666;
    localparam logic [31:0]  C2 = 32'hFFFF_FFFF;
    localparam logic [255:0] K3 = 256'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD_EEEEEEEE_12345678_9ABCDEF0_0BADF00D;
`ifdef CHUNK_STREAMER_AUTOINC_EN
    localparam logic [31:0]  ROW12_EXP = 32'h0000_0000;
`else
    localparam logic [31:0]  ROW12_EXP = 32'hFFFF_FFFF;
`endif

    logic clk = 1'b0;
    logic rst;

    chunk_streamer_if bus();

    chunk_streamer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_err;
        logic [1:0]  ctype;
        logic [31:0] word;
    } exp_t;

    typedef struct {
        logic        ld;
        logic [255:0] key;
        logic [95:0] nonce;
        logic [31:0] ctr;
        logic [1:0]  rtype;
        logic [4:0]  idx;
        logic        exp_err;
        logic [31:0] exp_word;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[14];

    int checks = 0;
    int fails  = 0;

    logic [255:0] m_key;
    logic [95:0]  m_nonce;
    logic [31:0]  m_ctr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [1:0] t, input logic [4:0] i);
        logic [31:0] w;
        w = 32'h0;
        case (t)
            2'd0: w = m_key[{i[2:0], 5'd0} +: 32];
            2'd1: begin
                if (i == 5'd0)      w = m_nonce[31:0];
                else if (i == 5'd1) w = m_nonce[63:32];
                else                w = m_nonce[95:64];
            end
            2'd2: w = m_ctr;
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    // Scoreboard: every valid or err pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && (bus.chunk_valid || bus.err)) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL sb_unexpected: valid=%b err=%b chunk=%h", bus.chunk_valid, bus.err, bus.chunk);
            end else begin
                mon_e = sb.pop_front();
                check("sb_kind", 32'({bus.chunk_valid, bus.err}), 32'({~mon_e.is_err, mon_e.is_err}));
                if (!mon_e.is_err) begin
                    check("sb_chunk", bus.chunk, mon_e.word);
                    check("sb_type", 32'(bus.chunk_type), 32'(mon_e.ctype));
                end
            end
        end
    end

    // One request; ld_k=0 loads alongside the request, ld_k>0 loads that many cycles later
    task automatic serve(input logic [1:0] t, input logic [4:0] i, input int ld_k,
                         input logic [255:0] k, input logic [95:0] n, input logic [31:0] c,
                         input logic exp_err, input logic [31:0] exp_word, input string tag);
        int seen_v;
        int seen_e;
        @(negedge clk);
        bus.chunk_request = 1'b1;
        bus.request_type  = t;
        bus.chunk_index   = i;
        if (ld_k == 0) begin
            bus.load_en = 1'b1; bus.load_key = k; bus.load_nonce = n; bus.load_counter = c;
            m_key = k; m_nonce = n; m_ctr = c;
        end
        sb.push_back('{exp_err, t, exp_word});
`ifdef CHUNK_STREAMER_AUTOINC_EN
        if (!exp_err && t == 2'd2) m_ctr = m_ctr + 32'd1;
`endif
        seen_v = -1;
        seen_e = -1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            bus.chunk_request = 1'b0;
            bus.load_en       = 1'b0;
            if (cyc == ld_k) begin
                bus.load_en = 1'b1; bus.load_key = k; bus.load_nonce = n; bus.load_counter = c;
            end
            if (bus.chunk_valid && seen_v < 0) seen_v = cyc;
            if (bus.err && seen_e < 0) seen_e = cyc;
            if (cyc == 1) check({tag, "_busy_hi"}, 32'(bus.busy), 32'd1);
            if (cyc == (exp_err ? 2 : 4)) check({tag, "_busy_lo"}, 32'(bus.busy), 32'd0);
        end
        bus.load_en = 1'b0;
        if (exp_err) begin
            check({tag, "_err_lat"}, 32'(seen_e), 32'd2);
            check({tag, "_no_valid"}, 32'(seen_v), 32'hFFFF_FFFF);
        end else begin
            check({tag, "_valid_lat"}, 32'(seen_v), 32'd3);
            check({tag, "_no_err"}, 32'(seen_e), 32'hFFFF_FFFF);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  st;
        logic [4:0]  si;
        logic [31:0] old_w;
        int cyc;
        int got;
        int last_v;

        tbl[0]  = '{1'b1, K1, N1, C1, 2'd0, 5'd3, 1'b0, 32'h0F0E0D0C};
        tbl[1]  = '{1'b0, '0, '0, '0, 2'd0, 5'd0, 1'b0, 32'h03020100};
        tbl[2]  = '{1'b0, '0, '0, '0, 2'd0, 5'd7, 1'b0, 32'h1F1E1D1C};
        tbl[3]  = '{1'b0, '0, '0, '0, 2'd1, 5'd0, 1'b0, 32'h01234567};
        tbl[4]  = '{1'b0, '0, '0, '0, 2'd1, 5'd2, 1'b0, 32'hCAFEBABE};
        tbl[5]  = '{1'b0, '0, '0, '0, 2'd1, 5'd3, 1'b1, 32'h0};
        tbl[6]  = '{1'b0, '0, '0, '0, 2'd3, 5'd0, 1'b1, 32'h0};
        tbl[7]  = '{1'b0, '0, '0, '0, 2'd0, 5'd8, 1'b1, 32'h0};
        tbl[8]  = '{1'b0, '0, '0, '0, 2'd2, 5'd1, 1'b1, 32'h0};
        tbl[9]  = '{1'b0, '0, '0, '0, 2'd2, 5'd0, 1'b0, 32'h00000010};
        tbl[10] = '{1'b1, K2, N2, C2, 2'd0, 5'd6, 1'b0, 32'hBBAA9988};
        tbl[11] = '{1'b0, '0, '0, '0, 2'd2, 5'd0, 1'b0, 32'hFFFFFFFF};
        tbl[12] = '{1'b0, '0, '0, '0, 2'd2, 5'd0, 1'b0, ROW12_EXP};
        tbl[13] = '{1'b0, '0, '0, '0, 2'd1, 5'd1, 1'b0, 32'h33334444};

        m_key = '0; m_nonce = '0; m_ctr = '0;
        rst = 1'b1;
        bus.load_en = 1'b0; bus.load_key = '0; bus.load_nonce = '0; bus.load_counter = '0;
        bus.chunk_request = 1'b0; bus.request_type = '0; bus.chunk_index = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_busy",  32'(bus.busy), 32'd0);
        check("rst_valid", 32'(bus.chunk_valid), 32'd0);
        check("rst_err",   32'(bus.err), 32'd0);
        check("rst_chunk", bus.chunk, 32'd0);
        check("rst_type",  32'(bus.chunk_type), 32'd0);
        rst = 1'b0;

        // Table of single requests (row 0 also checks first request after reset)
        for (int r = 0; r < 14; r++) begin
            serve(tbl[r].rtype, tbl[r].idx, tbl[r].ld ? 0 : -1, tbl[r].key, tbl[r].nonce,
                  tbl[r].ctr, tbl[r].exp_err, tbl[r].exp_word, $sformatf("row%0d", r));
        end

        // Request held high: key 0-7, nonce 0-2, counter 0, one chunk per 4 cycles
        @(negedge clk);
        bus.chunk_request = 1'b1;
        bus.request_type  = 2'd0;
        bus.chunk_index   = 5'd0;
        sb.push_back('{1'b0, 2'd0, model_word(2'd0, 5'd0)});
        cyc = 0; got = 0; last_v = 0;
        while (got < 12 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus.chunk_valid) begin
                if (got > 0) check("stream_period", 32'(cyc - last_v), 32'd4);
                else         check("stream_first_lat", 32'(cyc), 32'd3);
                last_v = cyc;
                got++;
                if (got < 12) begin
                    st = (got < 8) ? 2'd0 : (got < 11) ? 2'd1 : 2'd2;
                    si = (got < 8) ? 5'(got) : (got < 11) ? 5'(got - 8) : 5'd0;
                    bus.request_type = st;
                    bus.chunk_index  = si;
                    sb.push_back('{1'b0, st, model_word(st, si)});
`ifdef CHUNK_STREAMER_AUTOINC_EN
                    if (st == 2'd2) m_ctr = m_ctr + 32'd1;
`endif
                end else begin
                    bus.chunk_request = 1'b0;
                end
            end
        end
        bus.chunk_request = 1'b0;
        check("stream_count", 32'(got), 32'd12);
        repeat (3) @(negedge clk);

        // Load during LOOKUP is ignored; current and next chunks return old data
        old_w = model_word(2'd0, 5'd1);
        serve(2'd0, 5'd1, 1, K3, N1, C1, 1'b0, old_w, "lateload_cur");
        serve(2'd0, 5'd1, -1, '0, '0, '0, 1'b0, old_w, "lateload_next");
        serve(2'd2, 5'd0, -1, '0, '0, '0, 1'b0, m_ctr, "lateload_ctr");

        // Reset in the PRESENT cycle clears everything at once
        @(negedge clk);
        bus.chunk_request = 1'b1;
        bus.request_type  = 2'd0;
        bus.chunk_index   = 5'd5;
        @(negedge clk);
        bus.chunk_request = 1'b0;
        @(negedge clk);
        check("midrst_pre_chunk", bus.chunk, model_word(2'd0, 5'd5));
        check("midrst_pre_busy", 32'(bus.busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("midrst_valid", 32'(bus.chunk_valid), 32'd0);
        check("midrst_busy",  32'(bus.busy), 32'd0);
        check("midrst_chunk", bus.chunk, 32'd0);
        check("midrst_type",  32'(bus.chunk_type), 32'd0);
        @(negedge clk);
        check("midrst_hold_valid", 32'(bus.chunk_valid), 32'd0);
        rst = 1'b0;
        m_key = '0; m_nonce = '0; m_ctr = '0;
        serve(2'd2, 5'd0, -1, '0, '0, '0, 1'b0, 32'h0, "postrst_ctr");
        serve(2'd0, 5'd7, -1, '0, '0, '0, 1'b0, 32'h0, "postrst_key");

        repeat (4) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/chunk_streamer.md
CHUNK_STREAMER -- requirements
Module: chunk_streamer

Interface
REQ-001 The block SHALL use these ports, clock and reset first:
  clk  in  1  single clock; all state updates on rising edge
  rst  in  1  asynchronous, active-high reset
  load_en  in  1  capture load_key/load_nonce/load_counter; honoured only in IDLE
  load_key  in  256  key source; chunk i = bits [32i+31:32i]
  load_nonce  in  96  nonce source; chunk i = bits [32i+31:32i]
  load_counter  in  32  counter source
  chunk_request  in  1  consumer asks for one chunk
  request_type  in  2  0=key, 1=nonce, 2=counter, 3=illegal
  chunk_index  in  5  requested chunk number
  chunk_valid  out  1  one-cycle pulse; chunk/chunk_type valid
  chunk_type  out  2  type of the presented chunk
  chunk  out  32  chunk data
  busy  out  1  high in every state other than IDLE
  err  out  1  one-cycle pulse on an illegal request
REQ-002 The clock SHALL be the single clock clk, and the reset SHALL be rst, asynchronous and active-high.

Function
REQ-003 The FSM SHALL have states IDLE, LOOKUP, PRESENT and HOLDOFF; reset enters IDLE.
REQ-004 In IDLE, chunk_request=1 SHALL latch request_type and chunk_index and move to LOOKUP.
REQ-005 A request SHALL be legal when: type 0 with index 0-7; type 1 with index 0-2; type 2 with index 0.
REQ-006 In LOOKUP, a legal request SHALL register the selected 32-bit word into chunk and the latched type into chunk_type, then go to PRESENT.
REQ-007 In LOOKUP, an illegal request SHALL pulse err for one cycle (the cycle after LOOKUP), leave chunk_valid low and return to IDLE.
REQ-008 In PRESENT, chunk_valid SHALL be 1 for exactly one cycle, then the FSM SHALL go to HOLDOFF.
REQ-009 In HOLDOFF, the FSM SHALL ignore chunk_request for one cycle, then return to IDLE; this absorbs the consumer's stale request issued in the valid cycle.
REQ-010 Latency: with chunk_request sampled at edge N, chunk_valid SHALL be high in the cycle after edge N+2.
REQ-011 chunk_request SHALL be ignored in LOOKUP, PRESENT and HOLDOFF; it is neither queued nor flagged.
REQ-012 chunk and chunk_type SHALL hold their last presented values outside PRESENT; chunk_valid and err SHALL be 0 outside their pulse cycles.
REQ-013 load_en in IDLE SHALL overwrite all three stores on that edge.
REQ-014 load_en outside IDLE SHALL be ignored silently.
REQ-015 If load_en and chunk_request are both high in IDLE, the load SHALL take effect first and the request SHALL be served from the new values.

Reset
REQ-016 Asserting rst at any time, including mid-transfer, SHALL immediately force IDLE; busy, chunk_valid, err, chunk, chunk_type and all stores SHALL become 0.
REQ-017 After rst deasserts, the first request SHALL be served normally with no extra delay.

Configuration
REQ-018 Macro CHUNK_STREAMER_AUTOINC_EN defined: in the PRESENT cycle of a type-2 chunk, the stored counter SHALL increment by 1, wrapping 0xFFFFFFFF to 0x00000000; a load_en in the same cycle takes priority.
REQ-019 Macro CHUNK_STREAMER_AUTOINC_EN undefined: the stored counter SHALL change only on load_en or reset.

Verification
REQ-020 The bench SHALL cover these scenarios:
  a) Load key=0x1F1E..0100 (byte i = i); request type 0, index 3 -> chunk=0x0F0E0D0C, chunk_type=0, chunk_valid one cycle, 2 cycles after the sampling edge.
  b) Request type 1, index 3, then type 3, index 0 -> err pulses once each; chunk_valid never rises.
  c) chunk_request held high continuously, as the consumer does while waiting -> exactly one chunk_valid per 4-cycle IDLE-LOOKUP-PRESENT-HOLDOFF round; full key+nonce+counter sequence delivered in order.
  d) With AUTOINC: load counter=0xFFFFFFFF; request counter twice -> 0xFFFFFFFF then 0x00000000. Without AUTOINC: both return 0xFFFFFFFF.
  e) Assert rst in the PRESENT cycle -> chunk_valid drops at once and busy=0; a following request type 2 is served normally and returns 0x00000000.
  f) Assert load_en during LOOKUP with new data -> the current chunk returns old data; next request returns old data (load ignored).
